gpio_ex: RTL and testbench
==========================

GPIO_EX -- requirements
Module: gpio_ex

Interface
REQ-001 Parameter IN_CH, default 8: input-only channel count, 1..32.
REQ-002 Parameter OUT_CH, default 8: output-only channel count, 1..32.
REQ-003 Parameter IO_CH, default 16: bidirectional channel count, 1..32.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cs_  in  1  chip select, active low.
REQ-008 as_  in  1  address strobe, active low.
REQ-009 rw  in  1  1 = read, 0 = write.
REQ-010 addr  in  4  register index.
REQ-011 wr_data  in  32  write data.
REQ-012 rd_data  out  32  read data.
REQ-013 rdy_  out  1  ready, active low.
REQ-014 gpio_in  in  IN_CH  input pads.
REQ-015 gpio_out  out  OUT_CH  output pads, registered.
REQ-016 gpio_io  inout  IO_CH  bidirectional pads.
REQ-017 irq  out  1  level interrupt request, registered.

Function
REQ-018 Access SHALL occur when cs_=0 and as_=0; rdy_ SHALL be 0 exactly one cycle after each access cycle and 1 otherwise.
REQ-019 Read data SHALL appear on rd_data in the same cycle rdy_=0; rd_data SHALL be 0 in all other cycles. Unmapped addresses SHALL read 0 and ignore writes.
REQ-020 Register map: 0 IN_DATA (R); 1 OUT_DATA (R/W); 2 OUT_SET (W); 3 OUT_CLR (W); 4 OUT_TGL (W); 5 IO_DATA (R pad, W io_out); 6 IO_DIR (R/W, 1 = output); 7 RISE_EN (R/W); 8 FALL_EN (R/W); 9 IRQ_STAT (R, write-1-to-clear).
REQ-021 OUT_SET/OUT_CLR/OUT_TGL writes SHALL OR, AND-NOT and XOR wr_data[OUT_CH-1:0] into gpio_out respectively. Reads of these registers SHALL return 0.
REQ-022 Each gpio_io bit SHALL be driven by io_out when IO_DIR=1 and be high-Z when IO_DIR=0.
REQ-023 gpio_in and gpio_io SHALL each pass through a 2-flop synchronizer. IN_DATA and IO_DATA reads SHALL return the second-stage value, zero-extended to 32 bits.
REQ-024 All register reads SHALL be zero-extended; only the low CH bits of writes SHALL be used.
REQ-025 Edge detection SHALL compare synchronizer stage 2 with a stage-3 flop, per IN_CH bit. A rising edge (0->1) with RISE_EN=1, or a falling edge with FALL_EN=1, SHALL set the matching IRQ_STAT bit on the next clock.
REQ-026 If an edge event and a write-1-to-clear hit the same IRQ_STAT bit in the same cycle, the set SHALL win.
REQ-027 A read of IRQ_STAT SHALL return the value before any same-cycle update.
REQ-028 irq SHALL equal the OR of IRQ_STAT, registered, so it asserts 1 cycle after the status bit sets.
REQ-029 Clearing an enable bit SHALL NOT clear an already-set status bit.
REQ-030 A warm-up counter SHALL suppress edge events for the first 3 clocks after reset deasserts.

Reset
REQ-031 While reset=1, the following SHALL be 0: gpio_out, io_out, IO_DIR (all pads high-Z), RISE_EN, FALL_EN, IRQ_STAT, irq, rd_data and all synchronizer stages; rdy_ SHALL be 1.
REQ-032 Reset asserted mid-access SHALL abort the access; no rdy_=0 pulse SHALL follow.
REQ-033 Reset SHALL restart the warm-up counter.

Configuration
REQ-034 With macro GPIO_IRQ_EN defined, REQ-025..REQ-030 SHALL be implemented.
REQ-035 Without GPIO_IRQ_EN, addresses 7..9 SHALL read 0 and ignore writes. irq SHALL be constant 0, and no edge-detect or warm-up logic SHALL be instantiated.

Verification
REQ-036 Reset, then read addr 1 and addr 6 -> rd_data=0 with rdy_=0 one cycle after each access; all gpio_io high-Z.
REQ-037 Write OUT_DATA=0xF0, then OUT_SET=0x01, OUT_CLR=0x80, OUT_TGL=0x0F -> gpio_out sequence 0xF0, 0xF1, 0x71, 0x7E.
REQ-038 Write IO_DIR=0x00FF and IO_DATA=0xA5A5 -> gpio_io[7:0]=0xA5, [15:8]=Z; external drive 0x3C00 -> IO_DATA reads 0x3CA5 after 2 synchronizer clocks.
REQ-039 Set RISE_EN=0x01 and drive gpio_in[0] 0->1 -> IRQ_STAT=0x01 and irq=1 on the following clock. Write IRQ_STAT=0x01 -> irq=0. A new edge in the same cycle as the clear keeps the bit at 1.
REQ-040 Hold gpio_in=0xFF through reset release with RISE_EN=0xFF -> no IRQ_STAT bit sets. Build without GPIO_IRQ_EN -> addr 9 reads 0 and irq stays 0.

Source files
------------

// File: rtl/gpio_ex.sv
// GPIO block with input, output and bidirectional channels behind a small strobe-based register bus.
// Optional macro GPIO_IRQ_EN adds per-input edge detection, interrupt status and a level irq.
module gpio_ex #(
  parameter int unsigned IN_CH  = 8,
  parameter int unsigned OUT_CH = 8,
  parameter int unsigned IO_CH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [3:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rdy_,
  input  logic [IN_CH-1:0]  gpio_in,
  output logic [OUT_CH-1:0] gpio_out,
  inout  wire  [IO_CH-1:0]  gpio_io,
  output logic              irq
);

  localparam logic [3:0] A_IN_DATA  = 4'd0;
  localparam logic [3:0] A_OUT_DATA = 4'd1;
  localparam logic [3:0] A_OUT_SET  = 4'd2;
  localparam logic [3:0] A_OUT_CLR  = 4'd3;
  localparam logic [3:0] A_OUT_TGL  = 4'd4;
  localparam logic [3:0] A_IO_DATA  = 4'd5;
  localparam logic [3:0] A_IO_DIR   = 4'd6;
`ifdef GPIO_IRQ_EN
  localparam logic [3:0] A_RISE_EN  = 4'd7;
  localparam logic [3:0] A_FALL_EN  = 4'd8;
  localparam logic [3:0] A_IRQ_STAT = 4'd9;
  localparam logic [1:0] WU_DONE    = 2'd3;
`endif

  logic              access_c, wr_c;
  logic [31:0]       rd_mux_c;
  logic [31:0]       rd_d, rd_q;
  logic              rdy_d, rdy_q;
  logic [OUT_CH-1:0] out_d, out_q;
  logic [IO_CH-1:0]  io_out_d, io_out_q;
  logic [IO_CH-1:0]  io_dir_d, io_dir_q;
  logic [IN_CH-1:0]  in_s1_q, in_s2_q;
  logic [IO_CH-1:0]  io_s1_q, io_s2_q;
  logic              unused_wr;

`ifdef GPIO_IRQ_EN
  logic [IN_CH-1:0]  in_s3_q;
  logic [IN_CH-1:0]  rise_en_d, rise_en_q;
  logic [IN_CH-1:0]  fall_en_d, fall_en_q;
  logic [IN_CH-1:0]  stat_d, stat_q;
  logic [IN_CH-1:0]  clr_c, evt_c;
  logic [1:0]        wu_d, wu_q;
  logic              irq_q;
`endif

  assign access_c  = !cs_ && !as_;
  assign wr_c      = access_c && !rw;
  assign unused_wr = ^wr_data;

  // Pad drivers: each bidirectional bit floats unless its direction bit selects output.
  for (genvar i = 0; i < int'(IO_CH); i++) begin : g_io
    assign gpio_io[i] = io_dir_q[i] ? io_out_q[i] : 1'bz;
  end

  // Write decode, read mux and bus handshake next-state.
  always_comb begin
    out_d    = out_q;
    io_out_d = io_out_q;
    io_dir_d = io_dir_q;
    rd_mux_c = '0;
    if (wr_c) begin
      case (addr)
        A_OUT_DATA: out_d    = wr_data[OUT_CH-1:0];
        A_OUT_SET:  out_d    = out_q | wr_data[OUT_CH-1:0];
        A_OUT_CLR:  out_d    = out_q & ~wr_data[OUT_CH-1:0];
        A_OUT_TGL:  out_d    = out_q ^ wr_data[OUT_CH-1:0];
        A_IO_DATA:  io_out_d = wr_data[IO_CH-1:0];
        A_IO_DIR:   io_dir_d = wr_data[IO_CH-1:0];
        default:    ;
      endcase
    end
    case (addr)
      A_IN_DATA:  rd_mux_c = 32'(in_s2_q);
      A_OUT_DATA: rd_mux_c = 32'(out_q);
      A_IO_DATA:  rd_mux_c = 32'(io_s2_q);
      A_IO_DIR:   rd_mux_c = 32'(io_dir_q);
`ifdef GPIO_IRQ_EN
      A_RISE_EN:  rd_mux_c = 32'(rise_en_q);
      A_FALL_EN:  rd_mux_c = 32'(fall_en_q);
      A_IRQ_STAT: rd_mux_c = 32'(stat_q);
`endif
      default:    rd_mux_c = '0;
    endcase
    rd_d  = (access_c && rw) ? rd_mux_c : '0;
    rdy_d = !access_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= '0;
      rdy_q    <= 1'b1;
      out_q    <= '0;
      io_out_q <= '0;
      io_dir_q <= '0;
      in_s1_q  <= '0;
      in_s2_q  <= '0;
      io_s1_q  <= '0;
      io_s2_q  <= '0;
    end else begin
      rd_q     <= rd_d;
      rdy_q    <= rdy_d;
      out_q    <= out_d;
      io_out_q <= io_out_d;
      io_dir_q <= io_dir_d;
      in_s1_q  <= gpio_in;
      in_s2_q  <= in_s1_q;
      io_s1_q  <= gpio_io;
      io_s2_q  <= io_s1_q;
    end
  end

  assign rd_data  = rd_q;
  assign rdy_     = rdy_q;
  assign gpio_out = out_q;

`ifdef GPIO_IRQ_EN
  // Edge events set status; a same-cycle set beats a write-1-to-clear.
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_c     = '0;
    if (wr_c) begin
      case (addr)
        A_RISE_EN:  rise_en_d = wr_data[IN_CH-1:0];
        A_FALL_EN:  fall_en_d = wr_data[IN_CH-1:0];
        A_IRQ_STAT: clr_c     = wr_data[IN_CH-1:0];
        default:    ;
      endcase
    end
    evt_c = (in_s2_q & ~in_s3_q & rise_en_q) | (~in_s2_q & in_s3_q & fall_en_q);
    if (wu_q != WU_DONE) begin
      evt_c = '0;
    end
    stat_d = (stat_q & ~clr_c) | evt_c;
    wu_d   = (wu_q == WU_DONE) ? wu_q : wu_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_s3_q   <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      wu_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      in_s3_q   <= in_s2_q;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      wu_q      <= wu_d;
      irq_q     <= |stat_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_ex.sv
// Self-checking bench for gpio_ex: register table, synchronizer latency, reset abort and irq sequences.
module tb_gpio_ex;

  logic        clk;
  logic        reset;
  logic        cs_, as_, rw;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  wire  [15:0] gpio_io;
  logic        irq;
  logic [15:0] tb_en, tb_val;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        rw;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;
  vec_t vt[$];

  gpio_ex #(.IN_CH(8), .OUT_CH(8), .IO_CH(16)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_io(gpio_io), .irq(irq)
  );

  for (genvar i = 0; i < 16; i++) begin : g_pad
    assign gpio_io[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus access; the expected read word goes to the scoreboard.
  task automatic access(input logic r, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
    sb.push_back(r ? exp : 32'h0);
    @(posedge clk);
    #1;
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  // Every ready pulse must match a pending access; idle cycles must read 0.
  always @(negedge clk) begin
    if (rdy_ === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", 32'(rdy_), 32'h1);
      end else begin
        check("rd_data", rd_data, sb.pop_front());
      end
    end else begin
      check("rd_idle", rd_data, 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = 4'd0; wr_data = '0;
    gpio_in = 8'h00; tb_en = 16'hFFFF; tb_val = 16'h5A3C;

    vt.push_back('{1'b1, 4'd1, 32'h0,        32'h0,  8'h00});
    vt.push_back('{1'b1, 4'd6, 32'h0,        32'h0,  8'h00});
    vt.push_back('{1'b0, 4'd1, 32'hF0,       32'h0,  8'hF0});
    vt.push_back('{1'b0, 4'd2, 32'h01,       32'h0,  8'hF1});
    vt.push_back('{1'b0, 4'd3, 32'h80,       32'h0,  8'h71});
    vt.push_back('{1'b0, 4'd4, 32'h0F,       32'h0,  8'h7E});
    vt.push_back('{1'b1, 4'd1, 32'h0,        32'h7E, 8'h7E});
    vt.push_back('{1'b1, 4'd2, 32'h0,        32'h0,  8'h7E});
    vt.push_back('{1'b1, 4'd3, 32'h0,        32'h0,  8'h7E});
    vt.push_back('{1'b1, 4'd4, 32'h0,        32'h0,  8'h7E});
    vt.push_back('{1'b0, 4'd1, 32'hFFFFFF5A, 32'h0,  8'h5A});
    vt.push_back('{1'b1, 4'd1, 32'h0,        32'h5A, 8'h5A});
    vt.push_back('{1'b0, 4'hA, 32'h12,       32'h0,  8'h5A});
    vt.push_back('{1'b1, 4'hA, 32'h0,        32'h0,  8'h5A});
    vt.push_back('{1'b1, 4'hF, 32'h0,        32'h0,  8'h5A});
    vt.push_back('{1'b0, 4'd6, 32'hFFFF00FF, 32'h0,  8'h5A});
    vt.push_back('{1'b1, 4'd6, 32'h0,        32'hFF, 8'h5A});
    vt.push_back('{1'b0, 4'd5, 32'hA5A5,     32'h0,  8'h5A});

    // Reset state; the bench drives every pad so any DUT drive would disturb it.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_rdy", 32'(rdy_), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pads_hiz", 32'(gpio_io), 32'h5A3C);
    tb_en = 16'hFF00; tb_val = 16'h0000;
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      access(vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].exp_rd);
      check($sformatf("gpio_out[%0d]", i), 32'(gpio_out), 32'(vt[i].exp_out));
    end

    // Bidirectional pads: low byte driven by DUT, high byte by the bench.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("io_pads_a", 32'(gpio_io), 32'h00A5);
    tb_val = 16'h3C00;
    access(1'b1, 4'd5, 32'h0, 32'h00A5);
    access(1'b1, 4'd5, 32'h0, 32'h3CA5);
    check("io_pads_b", 32'(gpio_io), 32'h3CA5);

    // Input synchronizer: new value visible on the second read after the change.
    gpio_in = 8'hC3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    gpio_in = 8'h3C;
    access(1'b1, 4'd0, 32'h0, 32'hC3);
    access(1'b1, 4'd0, 32'h0, 32'h3C);

    // Reset during an access aborts it; inputs held high across the release.
    @(negedge clk);
    gpio_in = 8'hFF;
    reset = 1'b1; cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 4'd1; wr_data = 32'h11;
    @(posedge clk);
    #1;
    cs_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_gpio_out", 32'(gpio_out), 32'h0);
    access(1'b0, 4'd7, 32'hFF, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("warmup_irq", 32'(irq), 32'h0);
    access(1'b1, 4'd9, 32'h0, 32'h0);

`ifdef GPIO_IRQ_EN
    access(1'b1, 4'd7, 32'h0, 32'hFF);
    @(negedge clk);
    gpio_in = 8'hFE;
    repeat (4) @(posedge clk);
    access(1'b0, 4'd7, 32'h01, 32'h0);
    access(1'b1, 4'd9, 32'h0, 32'h0);
    // Rising edge on bit 0: status sets, irq follows one clock later.
    @(negedge clk);
    gpio_in = 8'hFF;
    repeat (2) @(posedge clk);
    access(1'b1, 4'd9, 32'h0, 32'h0);
    check("irq_before", 32'(irq), 32'h0);
    access(1'b1, 4'd9, 32'h0, 32'h01);
    check("irq_set", 32'(irq), 32'h1);
    access(1'b0, 4'd9, 32'h01, 32'h0);
    check("irq_hold", 32'(irq), 32'h1);
    @(posedge clk);
    #1;
    check("irq_cleared", 32'(irq), 32'h0);
    access(1'b1, 4'd9, 32'h0, 32'h0);
    // New edge in the same cycle as a clear: set wins.
    @(negedge clk);
    gpio_in = 8'hFE;
    repeat (4) @(posedge clk);
    @(negedge clk);
    gpio_in = 8'hFF;
    repeat (2) @(posedge clk);
    access(1'b0, 4'd9, 32'h01, 32'h0);
    access(1'b1, 4'd9, 32'h0, 32'h01);
    // Disabling the enable leaves status alone.
    access(1'b0, 4'd7, 32'h0, 32'h0);
    access(1'b1, 4'd9, 32'h0, 32'h01);
    check("irq_after_disable", 32'(irq), 32'h1);
    // Falling edge detection.
    access(1'b0, 4'd9, 32'h01, 32'h0);
    access(1'b0, 4'd8, 32'h01, 32'h0);
    @(negedge clk);
    gpio_in = 8'hFE;
    repeat (5) @(posedge clk);
    access(1'b1, 4'd9, 32'h0, 32'h01);
    access(1'b1, 4'd8, 32'h0, 32'h01);
`else
    access(1'b0, 4'd8, 32'hFF, 32'h0);
    access(1'b0, 4'd9, 32'hFF, 32'h0);
    access(1'b1, 4'd7, 32'h0, 32'h0);
    access(1'b1, 4'd8, 32'h0, 32'h0);
    access(1'b1, 4'd9, 32'h0, 32'h0);
    @(negedge clk);
    gpio_in = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    gpio_in = 8'hFF;
    repeat (6) @(posedge clk);
    #1;
    check("irq_off", 32'(irq), 32'h0);
    access(1'b1, 4'd9, 32'h0, 32'h0);
`endif

    repeat (4) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'h0);
    check("final_rdy", 32'(rdy_), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
